mdu_seq: RTL and testbench

- Multi-cycle multiply/divide sequencer for the pipeline EX stage.
- Performs MULT/MULTU/DIV/DIVU by sequencing a dedicated 32-bit ALU instance, one ALU operation per cycle.
- The ALU uses the existing 3-bit ALUctr encoding: 000 addu, 001 add, 010 or, 100 subu, 101 sub, 110 sltu, 111 slt.
- Produces HI/LO results with a start/busy/done handshake toward the hazard unit.

---
 rtl/mdu_seq.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mdu_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that drives an external 32-bit ALU, one operation per cycle.
// Optional MDU_DIV0_FLAG_EN adds a sticky div0 output flagging divide-by-zero completions.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [2:0]       alu_ctr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result
`ifdef MDU_DIV0_FLAG_EN
  ,
  output logic             div0
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] ALU_ADDU = 3'b000;
  localparam logic [2:0] ALU_SUBU = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  typedef enum logic [2:0] {
    IDLE, NEG_A, NEG_B, ITER_A, ITER_B, NEG_LO, NEG_HI, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             neg_p_q, neg_p_d;
  logic             neg_r_q, neg_r_d;
  logic             r_msb_q, r_msb_d;
  logic             lt_q, lt_d;
  logic             lz_q, lz_d;
  logic             done_q, done_d;
`ifdef MDU_DIV0_FLAG_EN
  logic             dz_q, dz_d;
  logic             div0_q, div0_d;
`endif

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] shl_acc;

  // op[1] selects divide, op[0] selects the signed variant.
  assign addend  = q_q[0] ? m_q : '0;
  assign shl_acc = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      sum_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
      r_msb_q <= 1'b0;
      lt_q    <= 1'b0;
      lz_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
      dz_q    <= 1'b0;
      div0_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      m_q     <= m_d;
      sum_q   <= sum_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_p_q <= neg_p_d;
      neg_r_q <= neg_r_d;
      r_msb_q <= r_msb_d;
      lt_q    <= lt_d;
      lz_q    <= lz_d;
      done_q  <= done_d;
`ifdef MDU_DIV0_FLAG_EN
      dz_q    <= dz_d;
      div0_q  <= div0_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    m_d     = m_q;
    sum_d   = sum_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_p_d = neg_p_q;
    neg_r_d = neg_r_q;
    r_msb_d = r_msb_q;
    lt_d    = lt_q;
    lz_d    = lz_q;
    done_d  = 1'b0;
    alu_ctr = ALU_ADDU;
    alu_a   = '0;
    alu_b   = '0;
`ifdef MDU_DIV0_FLAG_EN
    dz_d    = dz_q;
    div0_d  = div0_q;
`endif

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d  = op;
          acc_d = '0;
          q_d   = a;
          m_d   = b;
          cnt_d = '0;
`ifdef MDU_DIV0_FLAG_EN
          dz_d   = op[1] && (b == '0);
          div0_d = 1'b0;
`endif
          // Divide by zero bypasses the datapath entirely.
          if (op[1] && (b == '0)) begin
            acc_d   = a;
            q_d     = '1;
            state_d = DONE;
          end else if (op[0]) begin
            state_d = NEG_A;
          end else begin
            state_d = ITER_A;
          end
        end
      end
      NEG_A: begin
        alu_ctr = ALU_SUBU;
        alu_b   = q_q;
        neg_r_d = q_q[WIDTH-1];
        if (q_q[WIDTH-1]) q_d = alu_result;
        state_d = NEG_B;
      end
      NEG_B: begin
        alu_ctr = ALU_SUBU;
        alu_b   = m_q;
        neg_p_d = neg_r_q ^ m_q[WIDTH-1];
        if (m_q[WIDTH-1]) m_d = alu_result;
        state_d = ITER_A;
      end
      ITER_A: begin
        if (op_q[1]) begin
          // Restoring divide: the left shift of {acc,q} is folded into this compare.
          alu_ctr = ALU_SLTU;
          alu_a   = shl_acc;
          alu_b   = m_q;
          acc_d   = shl_acc;
          q_d     = {q_q[WIDTH-2:0], 1'b0};
          r_msb_d = acc_q[WIDTH-1];
          lt_d    = alu_result[0];
        end else begin
          alu_ctr = ALU_ADDU;
          alu_a   = acc_q;
          alu_b   = addend;
          sum_d   = alu_result;
        end
        state_d = ITER_B;
      end
      ITER_B: begin
        if (op_q[1]) begin
          alu_ctr = ALU_SUBU;
          alu_a   = acc_q;
          alu_b   = m_q;
          if (r_msb_q || !lt_q) begin
            acc_d = alu_result;
            q_d   = {q_q[WIDTH-1:1], 1'b1};
          end
        end else begin
          // sum < addend exactly when the add wrapped, recovering the carry out.
          alu_ctr = ALU_SLTU;
          alu_a   = sum_q;
          alu_b   = addend;
          acc_d   = {alu_result[0], sum_q[WIDTH-1:1]};
          q_d     = {sum_q[0], q_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = op_q[0] ? NEG_LO : DONE;
        else                         state_d = ITER_A;
      end
      NEG_LO: begin
        alu_ctr = ALU_SUBU;
        alu_b   = q_q;
        lz_d    = (q_q == '0);
        if (neg_p_q) q_d = alu_result;
        state_d = NEG_HI;
      end
      NEG_HI: begin
        if (op_q[1]) begin
          alu_ctr = ALU_SUBU;
          alu_b   = acc_q;
          if (neg_r_q) acc_d = alu_result;
        end else begin
          // High word of a 64-bit negate: ~hi plus the borrow out of the low word.
          alu_ctr = ALU_ADDU;
          alu_a   = ~acc_q;
          alu_b   = {{(WIDTH-1){1'b0}}, lz_q};
          if (neg_p_q) acc_d = alu_result;
        end
        state_d = DONE;
      end
      DONE: begin
        hi_d    = acc_q;
        lo_d    = q_q;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef MDU_DIV0_FLAG_EN
        if (dz_q) div0_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
`ifdef MDU_DIV0_FLAG_EN
      div0_d  = div0_q;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MDU_DIV0_FLAG_EN
  assign div0 = div0_q;
`endif

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: a behavioural ALU answers the sequencer, results and latencies are
// checked against hand-computed values.
module tb_mdu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo, alu_a, alu_b, alu_result;
  logic [2:0]   alu_ctr;
`ifdef MDU_DIV0_FLAG_EN
  logic         div0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int lat, bcnt, dcnt;
  logic [W-1:0] cap_hi, cap_lo;

  always #5 clk = ~clk;

  mdu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_ctr(alu_ctr), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
`ifdef MDU_DIV0_FLAG_EN
    , .div0(div0)
`endif
  );

  // Reference ALU with the pipeline's ALUctr encoding.
  always_comb begin
    alu_result = '0;
    case (alu_ctr)
      3'b000, 3'b001: alu_result = alu_a + alu_b;
      3'b010:         alu_result = alu_a | alu_b;
      3'b100, 3'b101: alu_result = alu_a - alu_b;
      3'b110:         alu_result = {{(W-1){1'b0}}, (alu_a < alu_b)};
      3'b111:         alu_result = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default:        alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a clock edge; returns edges-to-done in lat and busy-high cycles in bcnt.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    bcnt = busy ? 1 : 0;
    lat  = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
    end
    $display("[TB] op=%0d a=%h b=%h -> lat=%0d hi=%h lo=%h", av == 0 ? o : o, av, bv, lat, hi, lo);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_alu_ctr", 64'(alu_ctr), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_b", 64'(alu_b), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_lat", 64'(lat), 64'd65);
    check("multu_busy", 64'(bcnt), 64'd65);
    check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_lo", 64'(lo), 64'h0000_0001);
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'd0);
    check("idle_alu_ctr", 64'(alu_ctr), 64'd0);
    check("idle_alu_ops", {alu_a, alu_b}, 64'd0);

    run_op(2'b01, 32'hFFFF_FFF9, 32'd6);
    check("mult_lat", 64'(lat), 64'd69);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFD6);

    run_op(2'b01, 32'hFFFF_FFFD, 32'hFFFF_FFFB);
    check("mult_nn_hi", 64'(hi), 64'd0);
    check("mult_nn_lo", 64'(lo), 64'd15);

    run_op(2'b10, 32'd100, 32'd7);
    check("divu_lat", 64'(lat), 64'd65);
    check("divu_lo", 64'(lo), 64'd14);
    check("divu_hi", 64'(hi), 64'd2);

    run_op(2'b11, 32'hFFFF_FF9C, 32'd7);
    check("div_lat", 64'(lat), 64'd69);
    check("div_lo", 64'(lo), 64'hFFFF_FFF2);
    check("div_hi", 64'(hi), 64'hFFFF_FFFE);

    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_wrap_lo", 64'(lo), 64'h8000_0000);
    check("div_wrap_hi", 64'(hi), 64'd0);

    run_op(2'b10, 32'd5, 32'd0);
    check("div0_lat", 64'(lat), 64'd1);
    check("div0_hi", 64'(hi), 64'd5);
    check("div0_lo", 64'(lo), 64'hFFFF_FFFF);
`ifdef MDU_DIV0_FLAG_EN
    check("div0_flag", 64'(div0), 64'd1);
`endif

    // 0x80000000 * 2 signed exercises the borrow from the low word into the high word.
    run_op(2'b01, 32'h8000_0000, 32'd2);
    check("mult_min_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_min_lo", 64'(lo), 64'd0);
`ifdef MDU_DIV0_FLAG_EN
    check("div0_clear", 64'(div0), 64'd0);
`endif

    // Flush in the middle of a multiply.
    op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_after", 64'(busy), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("flush_no_done", 64'(dcnt), 64'd0);
    check("flush_hold_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'd0});
    $display("[TB] flush mid-multu -> busy=%b hi=%h lo=%h", busy, hi, lo);

    // Second start while busy must be ignored.
    op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    op = 2'b10; a = 32'd5; b = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dcnt = 0; cap_hi = '0; cap_lo = '0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dcnt++;
        cap_hi = hi;
        cap_lo = lo;
      end
    end
    check("busy_start_dones", 64'(dcnt), 64'd1);
    check("busy_start_result", {cap_hi, cap_lo}, {32'd0, 32'd12});
    $display("[TB] start while busy -> dones=%0d hi=%h lo=%h", dcnt, cap_hi, cap_lo);

    // Flush and start together in IDLE: flush wins.
    op = 2'b10; a = 32'd5; b = 32'd0; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("flush_start_done", 64'(done), 64'd0);
    check("flush_start_hilo", {hi, lo}, {32'd0, 32'd12});

    // Asynchronous reset in the middle of a divide.
    op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    check("arst_alu_ctr", 64'(alu_ctr), 64'd0);
    $display("[TB] async reset mid-divu -> busy=%b alu_ctr=%b", busy, alu_ctr);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
